// File: rtl/alarm_input_pkg.sv
// Shared types and sizing helpers for the alarm-clock input conditioner.
package alarm_input_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } key_state_e;

  localparam int unsigned MS_PER_S       = 1000;
  localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;

  // Clock cycles per 1 ms tick; never below one so the prescaler stays legal.
  function automatic int unsigned tick_count(input int unsigned clk_hz);
    return (clk_hz / MS_PER_S < 1) ? 1 : clk_hz / MS_PER_S;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/alarm_input_conditioner_if.sv
// Raw board inputs and conditioned PIO-facing outputs of the input conditioner.
interface alarm_input_conditioner_if;
  logic key_hours_n;
  logic key_minutes_n;
  logic key_off_n;
  logic sw_set_alarm;
  logic sw_set_clock;
  logic sw_reset;
  logic hours_o;
  logic minutes_o;
  logic off_o;
  logic set_alarm_o;
  logic set_clock_o;
  logic switch_reset_o;

  modport master (
    output key_hours_n, key_minutes_n, key_off_n,
    output sw_set_alarm, sw_set_clock, sw_reset,
    input  hours_o, minutes_o, off_o,
    input  set_alarm_o, set_clock_o, switch_reset_o
  );

  modport slave (
    input  key_hours_n, key_minutes_n, key_off_n,
    input  sw_set_alarm, sw_set_clock, sw_reset,
    output hours_o, minutes_o, off_o,
    output set_alarm_o, set_clock_o, switch_reset_o
  );
endinterface

// File: rtl/alarm_input_conditioner_debounce_cell.sv
// Two-flop synchroniser plus tick-based stable counter; level is the accepted value.
module debounce_cell
  import alarm_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_MS = 20,
  parameter bit          INVERT      = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_MS);

  logic          sync1;
  logic          sync2;
  logic          synced;
  logic [CW-1:0] stable_cnt;

  // Sync flops reset to the raw idle level so reset never looks like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= INVERT;
      sync2 <= INVERT;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  assign synced = sync2 ^ INVERT;

  always_ff @(posedge clk) begin
    if (rst) begin
      stable_cnt <= '0;
      level      <= 1'b0;
    end else if (synced == level) begin
      stable_cnt <= '0;
    end else if (tick) begin
      if (stable_cnt == CW'(DEBOUNCE_MS - 1)) begin
        level      <= synced;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alarm_input_conditioner.sv
// Debounces keys/switches, turns keys into stretched event pulses with
// auto-repeat on hours/minutes, and passes switches through as clean levels.
module alarm_input_conditioner
  import alarm_input_pkg::*;
#(
  parameter int unsigned CLK_HZ          = DEFAULT_CLK_HZ,
  parameter int unsigned DEBOUNCE_MS     = 20,
  parameter int unsigned REPEAT_DELAY_MS = 500,
  parameter int unsigned REPEAT_RATE_MS  = 150,
  parameter int unsigned PULSE_MS        = 10
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset,
  alarm_input_conditioner_if.slave  io
);

  localparam int unsigned TICK_COUNT = tick_count(CLK_HZ);
  localparam int unsigned PW         = cnt_width(TICK_COUNT - 1);
  localparam int unsigned TMAX       = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ?
                                       REPEAT_DELAY_MS : REPEAT_RATE_MS;
  localparam int unsigned TW         = cnt_width(TMAX);
  localparam int unsigned OW         = cnt_width(PULSE_MS);
  localparam logic [5:0]  INVERT_MASK = 6'b000111;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [5:0]    raw;
  logic [5:0]    level;
  logic [2:0]    pulse;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      presc_q <= '0;
      tick    <= 1'b0;
    end else if (presc_q == PW'(TICK_COUNT - 1)) begin
      presc_q <= '0;
      tick    <= 1'b1;
    end else begin
      presc_q <= presc_q + PW'(1);
      tick    <= 1'b0;
    end
  end

  // Bits 0..2 are the active-low keys, 3..5 the active-high switches.
  assign raw = {io.sw_reset, io.sw_set_clock, io.sw_set_alarm,
                io.key_off_n, io.key_minutes_n, io.key_hours_n};

  for (genvar i = 0; i < 6; i++) begin : g_deb
    debounce_cell #(
      .DEBOUNCE_MS (DEBOUNCE_MS),
      .INVERT      (INVERT_MASK[i])
    ) u_deb (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .tick  (tick),
      .raw   (raw[i]),
      .level (level[i])
    );
  end

  for (genvar k = 0; k < 3; k++) begin : g_key
    localparam bit REPEAT_EN = (k != 2);

    key_state_e    state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          ev_d, ev_q;
    logic [OW-1:0] pcnt_q;
    logic          pulse_q;

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        state_q <= IDLE;
        tcnt_q  <= '0;
        ev_q    <= 1'b0;
      end else begin
        state_q <= state_d;
        tcnt_q  <= tcnt_d;
        ev_q    <= ev_d;
      end
    end

    // Without repeat (off key) HOLD simply waits for release.
    always_comb begin
      state_d = state_q;
      tcnt_d  = tcnt_q;
      ev_d    = 1'b0;
      unique case (state_q)
        IDLE: begin
          if (level[k]) begin
            ev_d    = 1'b1;
            state_d = HOLD;
            tcnt_d  = '0;
          end
        end
        HOLD: begin
          if (!level[k]) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (REPEAT_EN && tick) begin
            if (tcnt_q == TW'(REPEAT_DELAY_MS - 1)) begin
              ev_d    = 1'b1;
              state_d = REPEAT;
              tcnt_d  = '0;
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        REPEAT: begin
          if (!level[k]) begin
            state_d = IDLE;
            tcnt_d  = '0;
          end else if (tick) begin
            if (tcnt_q == TW'(REPEAT_RATE_MS - 1)) begin
              ev_d   = 1'b1;
              tcnt_d = '0;
            end else begin
              tcnt_d = tcnt_q + TW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          tcnt_d  = '0;
        end
      endcase
    end

    always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
        pcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else if (ev_q) begin
        pcnt_q  <= OW'(PULSE_MS);
        pulse_q <= 1'b1;
      end else if (tick && (pcnt_q != '0)) begin
        pcnt_q  <= pcnt_q - OW'(1);
        pulse_q <= (pcnt_q != OW'(1));
      end
    end

    assign pulse[k] = pulse_q;
  end

  assign io.hours_o        = pulse[0];
  assign io.minutes_o      = pulse[1];
  assign io.off_o          = pulse[2];
  assign io.set_alarm_o    = level[3];
  assign io.set_clock_o    = level[4];
  assign io.switch_reset_o = level[5];

endmodule

// File: tb/tb_alarm_input_conditioner.sv
// Directed bench for alarm_input_conditioner with a 1-cycle tick (CLK_HZ=1000).
module tb_alarm_input_conditioner;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic smp  [0:80];
  logic smp2 [0:80];
  logic [5:0] outs;

  always #5 clk = ~clk;

  alarm_input_conditioner_if io ();

  alarm_input_conditioner #(
    .CLK_HZ          (1000),
    .DEBOUNCE_MS     (4),
    .REPEAT_DELAY_MS (20),
    .REPEAT_RATE_MS  (8),
    .PULSE_MS        (2)
  ) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .io          (io)
  );

  assign outs = {io.hours_o, io.minutes_o, io.off_o,
                 io.set_alarm_o, io.set_clock_o, io.switch_reset_o};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Index of the n-th (0-based) rising edge in smp[0..last], or -1.
  function automatic int nth_rise(input int n, input int last);
    int seen = 0;
    for (int i = 1; i <= last; i++) begin
      if (smp[i] && !smp[i-1]) begin
        if (seen == n) return i;
        seen++;
      end
    end
    return -1;
  endfunction

  function automatic int count_high(input int last);
    int c = 0;
    for (int i = 1; i <= last; i++) if (smp[i]) c++;
    return c;
  endfunction

  function automatic int count_rises(input int last);
    int c = 0;
    for (int i = 1; i <= last; i++) if (smp[i] && !smp[i-1]) c++;
    return c;
  endfunction

  task automatic clear_smp();
    for (int i = 0; i <= 80; i++) begin
      smp[i]  = 1'b0;
      smp2[i] = 1'b0;
    end
  endtask

  initial begin
    int nonzero;
    int exp_min [5];

    exp_min = '{8, 28, 36, 44, 52};
    rst = 1'b1;
    io.key_hours_n   = 1'b1;
    io.key_minutes_n = 1'b1;
    io.key_off_n     = 1'b1;
    io.sw_set_alarm  = 1'b0;
    io.sw_set_clock  = 1'b0;
    io.sw_reset      = 1'b0;
    step(3);
    check_val("reset_outs", 32'(outs), 32'd0);
    rst = 1'b0;

    nonzero = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (outs !== 6'd0) nonzero++;
    end
    check_val("idle_quiet", nonzero, 0);

    // 3-cycle glitch on hours: one cycle short of acceptance
    clear_smp();
    io.key_hours_n = 1'b0;
    for (int i = 1; i <= 33; i++) begin
      step(1);
      smp[i] = io.hours_o;
      if (i == 3) io.key_hours_n = 1'b1;
    end
    check_val("glitch_no_pulse", count_high(33), 0);

    // minutes held 50 cycles: first, delayed, then periodic pulses
    clear_smp();
    io.key_minutes_n = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      step(1);
      smp[i] = io.minutes_o;
      if (i == 50) io.key_minutes_n = 1'b1;
    end
    for (int j = 0; j < 5; j++)
      check_val($sformatf("min_rise%0d", j), nth_rise(j, 70), exp_min[j]);
    check_val("min_rise_count", count_rises(70), 5);
    check_val("min_high_cycles", count_high(70), 10);
    check_val("min_width_hi", smp[9], 1);
    check_val("min_width_lo", smp[10], 0);
    step(20);

    // off held 50 cycles: a single pulse
    clear_smp();
    io.key_off_n = 1'b0;
    for (int i = 1; i <= 70; i++) begin
      step(1);
      smp[i] = io.off_o;
      if (i == 50) io.key_off_n = 1'b1;
    end
    check_val("off_rise", nth_rise(0, 70), 8);
    check_val("off_rise_count", count_rises(70), 1);
    check_val("off_high_cycles", count_high(70), 2);
    step(20);

    // hours and minutes together
    clear_smp();
    io.key_hours_n   = 1'b0;
    io.key_minutes_n = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step(1);
      smp[i]  = io.hours_o;
      smp2[i] = io.minutes_o;
    end
    check_val("both_hours_rise", nth_rise(0, 12), 8);
    for (int i = 0; i <= 12; i++) smp[i] = smp2[i];
    check_val("both_min_rise", nth_rise(0, 12), 8);
    io.key_hours_n   = 1'b1;
    io.key_minutes_n = 1'b1;
    step(40);

    // set_clock with a 2-cycle bounce back to 0
    clear_smp();
    io.sw_set_clock = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      smp[i] = io.set_clock_o;
      if (i == 2)  io.sw_set_clock = 1'b0;
      if (i == 4)  io.sw_set_clock = 1'b1;
      if (i == 20) io.sw_set_clock = 1'b0;
    end
    check_val("sw_clk_rise", nth_rise(0, 40), 10);
    check_val("sw_clk_last_hi", smp[25], 1);
    check_val("sw_clk_fall", smp[26], 0);
    check_val("sw_clk_rise_count", count_rises(40), 1);

    // set_alarm and switch_reset together, clean edge
    clear_smp();
    io.sw_set_alarm = 1'b1;
    io.sw_reset     = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step(1);
      smp[i]  = io.set_alarm_o;
      smp2[i] = io.switch_reset_o;
    end
    check_val("sw_alarm_rise", nth_rise(0, 10), 6);
    for (int i = 0; i <= 10; i++) smp[i] = smp2[i];
    check_val("sw_reset_rise", nth_rise(0, 10), 6);
    check_val("sw_clk_stays_low", io.set_clock_o, 0);
    io.sw_set_alarm = 1'b0;
    io.sw_reset     = 1'b0;
    step(20);
    check_val("sw_released", 32'(outs), 32'd0);

    // reset during an hours pulse with the key still held
    clear_smp();
    io.key_hours_n = 1'b0;
    for (int i = 1; i <= 45; i++) begin
      step(1);
      smp[i] = io.hours_o;
      if (i == 8) rst = 1'b1;
      if (i == 9) rst = 1'b0;
    end
    check_val("rst_pre_pulse", smp[8], 1);
    check_val("rst_kills_pulse", smp[9], 0);
    check_val("rst_first_rise", nth_rise(0, 45), 8);
    check_val("rst_fresh_rise", nth_rise(1, 45), 17);
    check_val("rst_fresh_width", {smp[18], smp[19]}, 2'b10);
    check_val("rst_hold_rise", nth_rise(2, 45), 37);
    io.key_hours_n = 1'b1;
    step(40);
    check_val("final_quiet", 32'(outs), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
